// File: rtl/md_sched_if.sv
// EX-stage connection to the multiply/divide scheduler: issue fields,
// the ID hazard hint, and the HI/LO, status and stall outputs.
interface md_sched_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        id_md_use;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_md;
  logic        proto_err;

  modport master (
    output start, op, src_a, src_b, id_md_use,
    input  busy, hi, lo, stall_md, proto_err
  );

  modport slave (
    input  start, op, src_a, src_b, id_md_use,
    output busy, hi, lo, stall_md, proto_err
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler owning HI/LO: computes the result at issue,
// holds it for a fixed latency and commits it to HI/LO when the count expires.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_sched_if.slave   md
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;
  // How the pending value lands in {hi,lo} at commit.
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB, ACC_KEEP} acc_e;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  acc_e        acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        perr_q, perr_d;

  logic        busy;
  logic        is_md_op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe_s, q_mag, r_mag, q_s, r_s;
  logic [31:0] b_safe_u, q_u, r_u;

  // Arithmetic on the issue-cycle operands.
  always_comb begin
    prod_s   = {{32{md.src_a[31]}}, md.src_a} * {{32{md.src_b[31]}}, md.src_b};
    prod_u   = {32'd0, md.src_a} * {32'd0, md.src_b};
    // Signed divide through magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
    a_mag    = md.src_a[31] ? (32'd0 - md.src_a) : md.src_a;
    b_mag    = md.src_b[31] ? (32'd0 - md.src_b) : md.src_b;
    b_safe_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    q_s      = (md.src_a[31] ^ md.src_b[31]) ? (32'd0 - q_mag) : q_mag;
    r_s      = md.src_a[31] ? (32'd0 - r_mag) : r_mag;
    b_safe_u = (md.src_b == 32'd0) ? 32'd1 : md.src_b;
    q_u      = md.src_a / b_safe_u;
    r_u      = md.src_a % b_safe_u;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_SET;
      cnt_q   <= 4'd0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    perr_d  = perr_q;

    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          unique case (md.op)
            OP_MULT:  begin pend_d = prod_s; acc_d = ACC_SET; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_MULTU: begin pend_d = prod_u; acc_d = ACC_SET; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_MADD:  begin pend_d = prod_s; acc_d = ACC_ADD; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_MADDU: begin pend_d = prod_u; acc_d = ACC_ADD; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_MSUB:  begin pend_d = prod_s; acc_d = ACC_SUB; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_MSUBU: begin pend_d = prod_u; acc_d = ACC_SUB; cnt_d = MULT_CNT; state_d = S_BUSY; end
            OP_DIV: begin
              pend_d  = {r_s, q_s};
              acc_d   = (md.src_b == 32'd0) ? ACC_KEEP : ACC_SET;
              cnt_d   = DIV_CNT;
              state_d = S_BUSY;
            end
            OP_DIVU: begin
              pend_d  = {r_u, q_u};
              acc_d   = (md.src_b == 32'd0) ? ACC_KEEP : ACC_SET;
              cnt_d   = DIV_CNT;
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = md.src_a;
            OP_MTLO: lo_d = md.src_a;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        if (md.start) perr_d = 1'b1;
        if (cnt_q == 4'd1) begin
          unique case (acc_q)
            ACC_SET:  {hi_d, lo_d} = pend_q;
            ACC_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
            ACC_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
            ACC_KEEP: ;
          endcase
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    is_md_op     = (md.op >= OP_MULT) && (md.op <= OP_MSUBU);
    busy         = (state_q == S_BUSY);
    md.busy      = busy;
    md.stall_md  = md.id_md_use & (busy | (md.start & is_md_op));
    md.hi        = hi_q;
    md.lo        = lo_q;
    md.proto_err = perr_q;
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a reference model pushes expected {hi,lo}
// at issue and the value is popped and compared when the unit goes idle.
module tb_md_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sched_if mif();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = 64'(sa * sb);
    pu = ua * ub;
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        return {a % b, a / b};
      end
      4'd5:  return acc + ps;
      4'd6:  return acc + pu;
      4'd7:  return acc - ps;
      4'd8:  return acc - pu;
      4'd9:  return {a, acc[31:0]};
      4'd10: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = op;
    mif.src_a = a;
    mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0;
    mif.op    = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mif.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    logic [63:0] exp;
    int n;
    sb_q.push_back(model(op, a, b, {m_hi, m_lo}));
    start_op(op, a, b);
    wait_idle(n);
    checks++;
    if (n !== exp_cycles) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_cycles);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({mif.hi, mif.lo} !== exp) begin
      errors++;
      $display("FAIL %s hilo: got %h expected %h", name, {mif.hi, mif.lo}, exp);
    end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    mif.start = 1'b0; mif.op = 4'd0; mif.src_a = '0; mif.src_b = '0; mif.id_md_use = 1'b0;
    #12;
    checks++;
    if ({mif.hi, mif.lo, mif.busy, mif.proto_err, mif.stall_md} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: got %h/%h busy=%b perr=%b stall=%b expected all zero",
               mif.hi, mif.lo, mif.busy, mif.proto_err, mif.stall_md);
    end
    @(negedge clk) reset = 1'b1;
    m_hi = '0; m_lo = '0;
    start_op(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    checks++;
    if (mif.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mult_busy: got %b expected 1", mif.busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mif.busy, mif.hi, mif.lo} !== 65'd0) begin
      errors++;
      $display("FAIL async_abort: got busy=%b hi=%h lo=%h expected all zero", mif.busy, mif.hi, mif.lo);
    end
    @(negedge clk) reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({mif.busy, mif.hi, mif.lo} !== 65'd0) begin
      errors++;
      $display("FAIL no_commit_after_abort: got busy=%b hi=%h lo=%h expected all zero",
               mif.busy, mif.hi, mif.lo);
    end
  endtask

  task automatic test_mult;
    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5);
    checks++;
    if ({mif.hi, mif.lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL mult_const: got %h expected FFFFFFFFFFFFFFFE", {mif.hi, mif.lo});
    end
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
    checks++;
    if ({mif.hi, mif.lo} !== 64'h0000_0001_FFFF_FFFE) begin
      errors++;
      $display("FAIL multu_const: got %h expected 00000001FFFFFFFE", {mif.hi, mif.lo});
    end
  endtask

  task automatic test_div;
    run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    checks++;
    if ({mif.hi, mif.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg_const: got %h expected FFFFFFFFFFFFFFFD", {mif.hi, mif.lo});
    end
    run_op("mthi_preset", 4'd9,  32'h1234_5678, 32'd0, 0);
    run_op("mtlo_preset", 4'd10, 32'h1234_5678, 32'd0, 0);
    run_op("div_zero", 4'd3, 32'h55, 32'd0, 10);
    checks++;
    if ({mif.hi, mif.lo} !== 64'h1234_5678_1234_5678) begin
      errors++;
      $display("FAIL div_zero_const: got %h expected 1234567812345678", {mif.hi, mif.lo});
    end
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    checks++;
    if ({mif.hi, mif.lo} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const: got %h expected 0000000080000000", {mif.hi, mif.lo});
    end
    run_op("divu", 4'd4, 32'd100, 32'd7, 10);
    run_op("divu_big", 4'd4, 32'hFFFF_FFF0, 32'h0000_0003, 10);
  endtask

  task automatic test_madd;
    run_op("mthi", 4'd9,  32'd1, 32'd0, 0);
    run_op("mtlo", 4'd10, 32'd5, 32'd0, 0);
    run_op("madd", 4'd5, 32'd2, 32'd3, 5);
    checks++;
    if ({mif.hi, mif.lo} !== 64'h0000_0001_0000_000B) begin
      errors++;
      $display("FAIL madd_const: got %h expected 000000010000000B", {mif.hi, mif.lo});
    end
    run_op("mthi0", 4'd9, 32'd0, 32'd0, 0);
    run_op("msubu", 4'd8, 32'd1, 32'hC, 5);
    checks++;
    if ({mif.hi, mif.lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL msubu_const: got %h expected FFFFFFFFFFFFFFFF", {mif.hi, mif.lo});
    end
    run_op("msub", 4'd7, 32'd2, 32'hFFFF_FFFD, 5);
    run_op("maddu", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
  endtask

  task automatic test_stall;
    int stalls, n;
    logic [63:0] exp;
    sb_q.push_back(model(4'd1, 32'd7, 32'd6, {m_hi, m_lo}));
    @(negedge clk);
    mif.id_md_use = 1'b1;
    mif.start = 1'b1; mif.op = 4'd1; mif.src_a = 32'd7; mif.src_b = 32'd6;
    #1;
    stalls = (mif.stall_md === 1'b1) ? 1 : 0;
    @(negedge clk);
    mif.start = 1'b0; mif.op = 4'd0;
    n = 0;
    while (mif.busy === 1'b1 && n < 40) begin
      if (mif.stall_md === 1'b1) stalls++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (stalls !== 6 || n !== 5) begin
      errors++;
      $display("FAIL stall_cycles: got stalls=%0d busy=%0d expected 6 and 5", stalls, n);
    end
    checks++;
    if (mif.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got %b expected 0", mif.stall_md);
    end
    exp = sb_q.pop_front();
    checks++;
    if (mif.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL stall_lo: got %h expected %h", mif.lo, exp[31:0]);
    end
    {m_hi, m_lo} = exp;

    mif.id_md_use = 1'b0;
    sb_q.push_back(model(4'd2, 32'd9, 32'd9, {m_hi, m_lo}));
    start_op(4'd2, 32'd9, 32'd9);
    checks++;
    if (mif.busy !== 1'b1 || mif.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL no_use_no_stall: got busy=%b stall=%b expected 1 and 0", mif.busy, mif.stall_md);
    end
    wait_idle(n);
    exp = sb_q.pop_front();
    {m_hi, m_lo} = exp;

    @(negedge clk);
    mif.id_md_use = 1'b1;
    mif.start = 1'b1; mif.op = 4'd9; mif.src_a = 32'hABCD_0000;
    #1;
    checks++;
    if (mif.stall_md !== 1'b0) begin
      errors++;
      $display("FAIL mthi_no_stall: got %b expected 0", mif.stall_md);
    end
    @(negedge clk);
    mif.start = 1'b0; mif.op = 4'd0; mif.id_md_use = 1'b0;
    m_hi = 32'hABCD_0000;
  endtask

  task automatic test_proto;
    int n;
    logic [63:0] exp;
    checks++;
    if (mif.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_idle: got %b expected 0", mif.proto_err);
    end
    sb_q.push_back(model(4'd1, 32'h10, 32'h20, {m_hi, m_lo}));
    start_op(4'd1, 32'h10, 32'h20);
    @(negedge clk);
    mif.start = 1'b1; mif.op = 4'd4; mif.src_a = 32'd100; mif.src_b = 32'd3;
    @(negedge clk);
    mif.start = 1'b0; mif.op = 4'd0;
    checks++;
    if (mif.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_set: got %b expected 1", mif.proto_err);
    end
    wait_idle(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL proto_mult_len: got %0d expected 3", n);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({mif.hi, mif.lo} !== exp) begin
      errors++;
      $display("FAIL proto_mult_commit: got %h expected %h", {mif.hi, mif.lo}, exp);
    end
    repeat (15) @(negedge clk);
    checks++;
    if ({mif.busy, mif.proto_err, mif.hi, mif.lo} !== {2'b01, exp}) begin
      errors++;
      $display("FAIL proto_sticky_no_divu: got busy=%b perr=%b hilo=%h expected 0,1,%h",
               mif.busy, mif.proto_err, {mif.hi, mif.lo}, exp);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mif.proto_err, mif.hi, mif.lo} !== 65'd0) begin
      errors++;
      $display("FAIL proto_reset_clear: got perr=%b hilo=%h expected zero", mif.proto_err, {mif.hi, mif.lo});
    end
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_madd();
    test_stall();
    test_proto();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
